// File: rtl/math_pow2_arb.sv
// Round-robin arbiter/sequencer sharing one 2-cycle math_pow2 unit among NUM_REQ requesters.
// Define MATH_POW2_ARB_STATS_EN to add per-requester saturating grant counters on GRANT_CNT.
module math_pow2_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DOUT_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  input  logic [12*NUM_REQ-1:0] REQ_DIN,
  output logic [NUM_REQ-1:0]    REQ_READY,
  output logic [11:0]           POW_DIN,
  input  logic [DOUT_WIDTH-1:0] POW_DOUT,
  output logic                  RSP_VALID,
  output logic [IDW-1:0]        RSP_ID,
  output logic [DOUT_WIDTH-1:0] RSP_DOUT,
  input  logic                  RSP_READY
`ifdef MATH_POW2_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0] GRANT_CNT
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [IDW-1:0]        last_q, last_d, grant_idx, cand;
  logic                  grant_found, credit_ok, issue;
  logic [CW:0]           outstanding;
  logic                  s1_v_q, s2_v_q;
  logic [IDW-1:0]        s1_id_q, s2_id_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [IDW-1:0]        fifo_id_q   [FIFO_DEPTH];
  logic [DOUT_WIDTH-1:0] fifo_dout_q [FIFO_DEPTH];
  logic                  fifo_wr, fifo_rd;

  // Search starts one past the last winner and wraps.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!grant_found && REQ_VALID[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pops in the current cycle are not credited back until registered.
  assign outstanding = (CW+1)'(s1_v_q) + (CW+1)'(s2_v_q) + (CW+1)'(count_q);
  assign credit_ok   = outstanding < (CW+1)'(FIFO_DEPTH);
  assign issue       = rst_n && credit_ok && grant_found;

  always_comb begin
    REQ_READY = '0;
    POW_DIN   = 12'h000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue && grant_idx == IDW'(i)) begin
        REQ_READY[i] = 1'b1;
        POW_DIN      = REQ_DIN[12*i +: 12];
      end
    end
  end

  assign last_d    = issue ? grant_idx : last_q;
  assign fifo_wr   = s2_v_q;
  assign RSP_VALID = (count_q != '0);
  assign fifo_rd   = RSP_VALID && RSP_READY;
  assign count_d   = count_q + CW'(fifo_wr) - CW'(fifo_rd);
  assign RSP_ID    = RSP_VALID ? fifo_id_q[rd_ptr_q]   : '0;
  assign RSP_DOUT  = RSP_VALID ? fifo_dout_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q   <= IDW'(NUM_REQ - 1);
      s1_v_q   <= 1'b0;
      s1_id_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_id_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      last_q  <= last_d;
      s1_v_q  <= issue;
      s1_id_q <= grant_idx;
      s2_v_q  <= s1_v_q;
      s2_id_q <= s1_id_q;
      count_q <= count_d;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_id_q[wr_ptr_q]   <= s2_id_q;
      fifo_dout_q[wr_ptr_q] <= POW_DOUT;
    end
  end

`ifdef MATH_POW2_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && grant_idx == IDW'(i) && cnt_q[i] != 16'hFFFF)
          cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign GRANT_CNT[16*g +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_math_pow2_arb.sv
// Self-checking bench for math_pow2_arb with a behavioural 2-cycle math_pow2 model.
`timescale 1ns/1ps
module tb_math_pow2_arb;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int FD  = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [12*NR-1:0] req_din;
  logic [NR-1:0]    req_ready;
  logic [11:0]      pow_din;
  logic [DW-1:0]    pow_dout, p1, p2;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [DW-1:0]    rsp_dout;
  logic             rsp_ready;
`ifdef MATH_POW2_ARB_STATS_EN
  logic [16*NR-1:0] grant_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [IDW+DW-1:0] exp_q[$];
  logic [IDW+DW-1:0] act_q[$];
  int grant_q[$];

  always #5 clk = ~clk;

  math_pow2_arb #(.NUM_REQ(NR), .DOUT_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .REQ_VALID (req_valid),
    .REQ_DIN   (req_din),
    .REQ_READY (req_ready),
    .POW_DIN   (pow_din),
    .POW_DOUT  (pow_dout),
    .RSP_VALID (rsp_valid),
    .RSP_ID    (rsp_id),
    .RSP_DOUT  (rsp_dout),
    .RSP_READY (rsp_ready)
`ifdef MATH_POW2_ARB_STATS_EN
    ,
    .GRANT_CNT (grant_cnt)
`endif
  );

  // floor(2^(d/64)) truncated to DW bits; operands kept below 2^11 magnitude.
  function automatic logic [DW-1:0] pow2_ref(input logic [11:0] d);
    real    r;
    longint v;
    r = (2.0 ** (real'(d[5:0]) / 64.0)) * (2.0 ** real'(d[11:6]));
    v = longint'($floor(r));
    return v[DW-1:0];
  endfunction

  always @(posedge clk) begin
    p1 <= pow2_ref(pow_din);
    p2 <= p1;
  end
  assign pow_dout = p2;

  // Scoreboard: expectations on issue, observed responses on pop.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({IDW'(i), pow2_ref(req_din[12*i +: 12])});
          grant_q.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) act_q.push_back({rsp_id, rsp_dout});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    act_q.delete();
    grant_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_din = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
    n_total++; if (pow_din !== 12'h000) $display("FAIL reset_pow_din: got %h want 000", pow_din); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else n_pass++;
    n_total++; if (rsp_dout !== 8'd0) $display("FAIL reset_rsp_dout: got %0d want 0", rsp_dout); else n_pass++;
`ifdef MATH_POW2_ARB_STATS_EN
    n_total++; if (grant_cnt !== '0) $display("FAIL reset_grant_cnt: got %h want 0", grant_cnt); else n_pass++;
`endif
    tick();
    rst_n = 1'b1;
    tick();
    clear_sb();
  endtask

  task automatic test_single();
    clear_sb();
    req_din[11:0] = 12'h040; req_valid = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else n_pass++;
    n_total++; if (pow_din !== 12'h040) $display("FAIL single_pow_din: got %h want 040", pow_din); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      @(negedge clk);
      if (k < 3) begin
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid: cycle t+%0d got %b want 0", k, rsp_valid); else n_pass++;
      end else begin
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL single_latency: got %b want 1 at t+3", rsp_valid); else n_pass++;
        n_total++; if (rsp_id !== 2'd0) $display("FAIL single_id: got %0d want 0", rsp_id); else n_pass++;
        n_total++; if (rsp_dout !== 8'd2) $display("FAIL single_dout: got %0d want 2", rsp_dout); else n_pass++;
      end
    end
    repeat (3) tick();
    n_total++; if (act_q.size() != 1 || exp_q.size() != 1) $display("FAIL single_count: got %0d rsp want 1", act_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      logic [IDW+DW-1:0] a, e;
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (a !== e) $display("FAIL single_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1;
    clear_sb();
    for (int i = 0; i < NR; i++) req_din[12*i +: 12] = 12'(12'h040 * i);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    repeat (16) tick();
    req_valid = '0;
    repeat (6) tick();
    n_total++; if (grant_q.size() != 16) $display("FAIL rr_throughput: got %0d grants want 16", grant_q.size()); else n_pass++;
    for (int k = 0; k < grant_q.size() && k < 16; k++) begin
      n_total++; if (grant_q[k] != k % NR) $display("FAIL rr_order: grant %0d got req %0d want %0d", k, grant_q[k], k % NR); else n_pass++;
    end
    n_total++; if (act_q.size() != exp_q.size()) $display("FAIL rr_count: got %0d rsp want %0d", act_q.size(), exp_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      logic [IDW+DW-1:0] a, e;
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (a !== e) $display("FAIL rr_sb: got %h want %h", a, e); else n_pass++;
      n_total++; if (a[DW-1:0] !== 8'(1 << a[DW +: IDW])) $display("FAIL rr_dout: id %0d got %0d want %0d", a[DW +: IDW], a[DW-1:0], 1 << a[DW +: IDW]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [IDW-1:0] h_id;
    logic [DW-1:0]  h_dout;
    clear_sb();
    rsp_ready = 1'b0; req_din[35:24] = 12'h1C0; req_valid = 4'b0100;
    repeat (10) tick();
    @(negedge clk);
    n_total++; if (grant_q.size() != FD) $display("FAIL bp_issues: got %0d want %0d", grant_q.size(), FD); else n_pass++;
    n_total++; if (req_ready !== 4'b0) $display("FAIL bp_ready_low: got %b want 0", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_dout !== 8'd128) $display("FAIL bp_head: got v%b id%0d d%0d want v1 id2 d128", rsp_valid, rsp_id, rsp_dout); else n_pass++;
    h_id = rsp_id; h_dout = rsp_dout;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== h_id || rsp_dout !== h_dout) $display("FAIL bp_hold: got v%b id%0d d%0d want v1 id%0d d%0d", rsp_valid, rsp_id, rsp_dout, h_id, h_dout); else n_pass++;
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0) $display("FAIL bp_no_early_credit: got %b want 0", req_ready); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0100) $display("FAIL bp_resume: got %b want 0100", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    repeat (10) tick();
    n_total++; if (act_q.size() != exp_q.size() || act_q.size() <= FD) $display("FAIL bp_count: got %0d rsp want %0d (>%0d)", act_q.size(), exp_q.size(), FD); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      logic [IDW+DW-1:0] a, e;
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (a !== e || a !== {2'd2, 8'd128}) $display("FAIL bp_sb: got %h want %h", a, {2'd2, 8'd128}); else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    clear_sb();
    rsp_ready = 1'b1;
    req_din[11:0] = 12'h080; req_din[23:12] = 12'h0C0;
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_total++; if (grant_q.size() != 2) $display("FAIL mid_issues: got %0d want 2", grant_q.size()); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL mid_discard: cycle %0d got %b want 0", k, rsp_valid); else n_pass++;
      tick();
    end
    clear_sb();
    req_valid = 4'b1111;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0001) $display("FAIL mid_last_reset: got %b want 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    repeat (5) tick();
    n_total++; if (act_q.size() != 1 || exp_q.size() != 1) $display("FAIL mid_count: got %0d rsp want 1", act_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      logic [IDW+DW-1:0] a, e;
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (a !== e || a !== {2'd0, 8'd4}) $display("FAIL mid_sb: got %h want %h", a, {2'd0, 8'd4}); else n_pass++;
    end
  endtask

  task automatic test_full_minus_one();
    clear_sb();
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) req_din[12*i +: 12] = 12'(12'h040 * i);
    req_valid = 4'b0010; tick();
    req_valid = 4'b0100; tick();
    req_valid = 4'b1000; tick();
    req_valid = '0;
    repeat (3) tick();
    req_valid = 4'b0001;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0001) $display("FAIL fm1_grant: got %b want 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) $display("FAIL fm1_head: got v%b id%0d want v1 id1", rsp_valid, rsp_id); else n_pass++;
    repeat (8) tick();
    n_total++; if (act_q.size() != 4 || exp_q.size() != 4) $display("FAIL fm1_count: got %0d rsp want 4", act_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      logic [IDW+DW-1:0] a, e;
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (a !== e) $display("FAIL fm1_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

  task automatic test_random();
    int            inflight, rr_last, idx;
    bit            found;
    logic [NR-1:0] exp_ready;
    logic [11:0]   exp_pow;
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1;
    clear_sb();
    rr_last = NR - 1;
    for (int c = 0; c < 300; c++) begin
      req_valid = NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) req_din[12*i +: 12] = 12'($urandom_range(0, 12'h2BF));
      rsp_ready = ($urandom_range(0, 3) != 0);
      inflight = exp_q.size() - act_q.size();
      @(negedge clk);
      exp_ready = '0; exp_pow = 12'h000; found = 1'b0;
      if (inflight < FD) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (rr_last + k) % NR;
          if (!found && req_valid[idx]) begin
            found = 1'b1; exp_ready[idx] = 1'b1; exp_pow = req_din[12*idx +: 12]; rr_last = idx;
          end
        end
      end
      n_total++; if (req_ready !== exp_ready) $display("FAIL rnd_grant: cycle %0d got %b want %b", c, req_ready, exp_ready); else n_pass++;
      n_total++; if (pow_din !== exp_pow) $display("FAIL rnd_pow_din: cycle %0d got %h want %h", c, pow_din, exp_pow); else n_pass++;
      tick();
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (12) tick();
    n_total++; if (act_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d rsp want %0d", act_q.size(), exp_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      logic [IDW+DW-1:0] a, e;
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (a !== e) $display("FAIL rnd_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

`ifdef MATH_POW2_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0010; rsp_ready = 1'b1;
    repeat (1000) tick();
    @(negedge clk);
    n_total++; if (grant_cnt[31:16] !== 16'd1000) $display("FAIL stats_mid: got %0d want 1000", grant_cnt[31:16]); else n_pass++;
    repeat (69000) tick();
    req_valid = '0;
    repeat (6) tick();
    n_total++; if (grant_cnt[31:16] !== 16'hFFFF) $display("FAIL stats_sat: got %h want ffff", grant_cnt[31:16]); else n_pass++;
    n_total++; if (grant_cnt[15:0] !== 16'h0 || grant_cnt[63:32] !== 32'h0) $display("FAIL stats_others: got %h want 0 outside [31:16]", grant_cnt); else n_pass++;
    clear_sb();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_full_minus_one();
    test_random();
`ifdef MATH_POW2_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
